imem_loader: RTL and testbench

- Instruction-memory stage directly upstream of the 8-bit single-cycle core.
- Holds a 256-byte program image and drives the core's `inst` from the core's `pc`, combinationally, in the same cycle.
- Programs are streamed in byte-wise over a valid/ready port.
- Gates core execution through `cpu_run` until a complete image is present.

---
 rtl/imem_loader_if.sv | 37 +++
 rtl/imem_loader.sv | 219 +++++++++++++++++++++
 tb/tb_imem_loader.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
//------------------------------------------------------------------------------
// imem_loader_if
//
// Byte-wise program load stream into the instruction memory loader.
//
//   load_start : one-cycle request to begin (or restart) a program load
//   load_valid : load_data carries a valid byte
//   load_data  : instruction byte
//   load_last  : accepted byte is the final byte of the image
//   load_ready : loader can accept a byte this cycle
//
// master : the program source (drives start/valid/data/last)
// slave  : the loader (drives ready)
//------------------------------------------------------------------------------
interface imem_loader_if;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface : imem_loader_if

// File: rtl/imem_loader.sv
//------------------------------------------------------------------------------
// imem_loader
//
// Instruction memory sitting directly in front of the 8-bit single-cycle core.
// Holds a DEPTH-byte program image, streams new images in over a valid/ready
// byte port and holds the core off (cpu_run=0) until a complete image exists.
// The instruction read path is combinational: inst follows pc in the same
// cycle.
//
// Ports:
//   clk       : system clock (same divided clock as the core), rising edge
//   reset     : asynchronous, active-low reset; aborts to CLEAR
//   ld        : load stream (slave side) - start/valid/data/last in, ready out
//   pc        : core program counter
//   inst      : instruction to the core (NOP_INST when not running / pc OOB)
//   cpu_run   : core execution enable
//   busy      : high while clearing memory or loading an image
//   prog_len  : number of bytes in the current image (0..DEPTH)
//   pc_oob    : running and pc >= prog_len
//   overflow  : last load filled DEPTH bytes without load_last; sticky until
//               the next load_start
//------------------------------------------------------------------------------
module imem_loader #(
    parameter int         DEPTH    = 256,
    parameter logic [7:0] NOP_INST = 8'h00
) (
    input  logic               clk,
    input  logic               reset,
    imem_loader_if.slave       ld,
    input  logic [7:0]         pc,
    output logic [7:0]         inst,
    output logic               cpu_run,
    output logic               busy,
    output logic [8:0]         prog_len,
    output logic               pc_oob,
    output logic               overflow
);

    // Address space is fixed at 8 bits, so DEPTH cannot exceed 256.
    localparam logic [7:0] LAST_ADDR = 8'(DEPTH - 1);
    localparam logic [8:0] DEPTH_LEN = 9'(DEPTH);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    state_e     state_q;
    logic [7:0] clr_ptr_q;
    logic [7:0] wr_ptr_q;
    logic [8:0] prog_len_q;
    logic       overflow_q;
    logic       cpu_run_q;
    logic       load_ready_q;
    logic       busy_q;

    logic [7:0] mem [0:DEPTH-1];

    logic       beat_acc;
    logic       beat_at_end;
    logic       mem_we;
    logic [7:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       pc_in_range;
    logic       running;

    // A beat presented in the same cycle as a restart is dropped, so
    // load_start masks acceptance even though load_ready is still high.
    assign beat_acc    = (state_q == S_LOAD) && ld.load_valid && load_ready_q
                         && !ld.load_start;
    assign beat_at_end = (wr_ptr_q == LAST_ADDR);

    //--------------------------------------------------------------------------
    // Memory write port: CLEAR zeroes one byte per cycle, LOAD writes beats.
    //--------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = clr_ptr_q;
        mem_wdata = 8'h00;
        case (state_q)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = 8'h00;
            end
            S_LOAD: begin
                if (beat_acc) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_q;
                    mem_wdata = ld.load_data;
                end
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    // Storage itself has no reset; the CLEAR sweep provides a known image.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    //--------------------------------------------------------------------------
    // Control FSM with registered outputs. Outputs are assigned from the state
    // being entered, so cpu_run/load_ready/busy change on the transition edge.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_CLEAR;
            clr_ptr_q    <= 8'h00;
            wr_ptr_q     <= 8'h00;
            prog_len_q   <= 9'd0;
            overflow_q   <= 1'b0;
            cpu_run_q    <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            case (state_q)
                S_CLEAR: begin
                    // load_start is deliberately ignored here, not queued.
                    if (clr_ptr_q == LAST_ADDR) begin
                        state_q   <= S_IDLE;
                        clr_ptr_q <= 8'h00;
                        busy_q    <= 1'b0;
                    end else begin
                        clr_ptr_q <= clr_ptr_q + 8'h01;
                    end
                end

                S_IDLE: begin
                    if (ld.load_start) begin
                        state_q      <= S_LOAD;
                        wr_ptr_q     <= 8'h00;
                        prog_len_q   <= 9'd0;
                        overflow_q   <= 1'b0;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cpu_run_q    <= 1'b0;
                    end
                end

                S_LOAD: begin
                    if (ld.load_start) begin
                        // Restart: discard what was written so far.
                        wr_ptr_q   <= 8'h00;
                        prog_len_q <= 9'd0;
                        overflow_q <= 1'b0;
                    end else if (beat_acc) begin
                        if (prog_len_q != DEPTH_LEN) begin
                            prog_len_q <= prog_len_q + 9'd1;
                        end
                        if (ld.load_last || beat_at_end) begin
                            // Final beat, either explicit or forced by a full
                            // memory; wr_ptr stays put so it never wraps.
                            state_q      <= S_RUN;
                            overflow_q   <= !ld.load_last;
                            load_ready_q <= 1'b0;
                            busy_q       <= 1'b0;
                            cpu_run_q    <= 1'b1;
                        end else begin
                            wr_ptr_q <= wr_ptr_q + 8'h01;
                        end
                    end
                end

                S_RUN: begin
                    if (ld.load_start) begin
                        state_q      <= S_LOAD;
                        wr_ptr_q     <= 8'h00;
                        prog_len_q   <= 9'd0;
                        overflow_q   <= 1'b0;
                        load_ready_q <= 1'b1;
                        busy_q       <= 1'b1;
                        cpu_run_q    <= 1'b0;
                    end
                end

                default: begin
                    state_q      <= S_CLEAR;
                    clr_ptr_q    <= 8'h00;
                    cpu_run_q    <= 1'b0;
                    load_ready_q <= 1'b0;
                    busy_q       <= 1'b1;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Combinational read path: zero-latency from pc, masked outside RUN and
    // beyond the loaded image.
    //--------------------------------------------------------------------------
    assign running     = (state_q == S_RUN);
    assign pc_in_range = ({1'b0, pc} < prog_len_q);

    always_comb begin
        inst   = NOP_INST;
        pc_oob = 1'b0;
        if (running) begin
            if (pc_in_range) begin
                inst = mem[pc];
            end else begin
                pc_oob = 1'b1;
            end
        end
    end

    assign ld.load_ready = load_ready_q;
    assign cpu_run       = cpu_run_q;
    assign busy          = busy_q;
    assign prog_len      = prog_len_q;
    assign overflow      = overflow_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
//------------------------------------------------------------------------------
// tb_imem_loader
//
// Directed self-checking bench for imem_loader: reset state, CLEAR duration,
// basic load/run, valid gaps, overflow on a full image, restart mid-load and
// asynchronous reset while running.
//------------------------------------------------------------------------------
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic [7:0] inst;
    logic       cpu_run;
    logic       busy;
    logic [8:0] prog_len;
    logic       pc_oob;
    logic       overflow;

    int total;
    int bad;

    imem_loader_if ldif ();

    imem_loader #(
        .DEPTH    (256),
        .NOP_INST (8'h00)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ld       (ldif),
        .pc       (pc),
        .inst     (inst),
        .cpu_run  (cpu_run),
        .busy     (busy),
        .prog_len (prog_len),
        .pc_oob   (pc_oob),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ldif.load_start = 1'b1;
        step();
        ldif.load_start = 1'b0;
    endtask

    task automatic beat(input logic [7:0] d, input logic last);
        ldif.load_valid = 1'b1;
        ldif.load_data  = d;
        ldif.load_last  = last;
        step();
        ldif.load_valid = 1'b0;
        ldif.load_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        pc    = 8'h05;
        step();
        step();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%0h want=1", busy); end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL rst_cpu_run got=%0h want=0", cpu_run); end
        total++; if (ldif.load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0h want=0", ldif.load_ready); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL rst_prog_len got=%0d want=0", prog_len); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_overflow got=%0h want=0", overflow); end
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL rst_inst got=%0h want=00", inst); end
        total++; if (pc_oob !== 1'b0) begin bad++; $display("FAIL rst_pc_oob got=%0h want=0", pc_oob); end
    endtask

    // Release reset mid-cycle and count busy cycles; a load_start pulse in
    // the middle of CLEAR must be ignored.
    task automatic test_clear();
        int n;
        @(negedge clk);
        reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            ldif.load_start = (n == 10);
            step();
            n++;
        end
        ldif.load_start = 1'b0;
        pc = 8'h05;
        #1;
        total++; if (n !== 256) begin bad++; $display("FAIL clear_cycles got=%0d want=256", n); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL clear_busy_after got=%0h want=0", busy); end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL clear_cpu_run got=%0h want=0", cpu_run); end
        total++; if (ldif.load_ready !== 1'b0) begin bad++; $display("FAIL clear_start_ignored got=%0h want=0", ldif.load_ready); end
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL clear_inst got=%0h want=00", inst); end
    endtask

    task automatic test_basic_load();
        logic [7:0] exp_inst [4];
        exp_inst = '{8'h41, 8'h82, 8'hC3, 8'h00};
        pulse_start();
        total++; if (ldif.load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%0h want=1", ldif.load_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%0h want=1", busy); end
        beat(8'h41, 1'b0);
        beat(8'h82, 1'b0);
        total++; if (ldif.load_ready !== 1'b1) begin bad++; $display("FAIL basic_ready_mid got=%0h want=1", ldif.load_ready); end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL basic_run_mid got=%0h want=0", cpu_run); end
        beat(8'hC3, 1'b1);
        total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL basic_cpu_run got=%0h want=1", cpu_run); end
        total++; if (prog_len !== 9'd3) begin bad++; $display("FAIL basic_prog_len got=%0d want=3", prog_len); end
        total++; if (ldif.load_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_run got=%0h want=0", ldif.load_ready); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL basic_overflow got=%0h want=0", overflow); end
        for (int i = 0; i < 4; i++) begin
            pc = 8'(i);
            #1;
            total++; if (inst !== exp_inst[i]) begin bad++; $display("FAIL basic_inst pc=%0d got=%0h want=%0h", i, inst, exp_inst[i]); end
            total++; if (pc_oob !== (i == 3)) begin bad++; $display("FAIL basic_pc_oob pc=%0d got=%0h want=%0h", i, pc_oob, (i == 3)); end
        end
    endtask

    task automatic test_gaps();
        logic [7:0] exp_inst [3];
        exp_inst = '{8'h10, 8'h20, 8'h30};
        pulse_start();
        beat(8'h10, 1'b0);
        ldif.load_data = 8'hFF;
        ldif.load_last = 1'b1;   // last without valid must be ignored
        step();
        step();
        ldif.load_last = 1'b0;
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL gap_prog_len1 got=%0d want=1", prog_len); end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL gap_last_no_valid got=%0h want=0", cpu_run); end
        beat(8'h20, 1'b0);
        ldif.load_data = 8'hFF;
        step();
        step();
        step();
        total++; if (prog_len !== 9'd2) begin bad++; $display("FAIL gap_prog_len2 got=%0d want=2", prog_len); end
        beat(8'h30, 1'b1);
        total++; if (prog_len !== 9'd3) begin bad++; $display("FAIL gap_prog_len3 got=%0d want=3", prog_len); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i);
            #1;
            total++; if (inst !== exp_inst[i]) begin bad++; $display("FAIL gap_inst pc=%0d got=%0h want=%0h", i, inst, exp_inst[i]); end
        end
        pc = 8'h03;
        #1;
        total++; if (pc_oob !== 1'b1) begin bad++; $display("FAIL gap_pc_oob got=%0h want=1", pc_oob); end
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 255; i++) begin
            beat(8'(i), 1'b0);
        end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL ovf_run_early got=%0h want=0", cpu_run); end
        total++; if (prog_len !== 9'd255) begin bad++; $display("FAIL ovf_len_255 got=%0d want=255", prog_len); end
        beat(8'hFF, 1'b0);
        total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL ovf_cpu_run got=%0h want=1", cpu_run); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0h want=1", overflow); end
        total++; if (prog_len !== 9'd256) begin bad++; $display("FAIL ovf_prog_len got=%0d want=256", prog_len); end
        total++; if (ldif.load_ready !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%0h want=0", ldif.load_ready); end
        pc = 8'hFF;
        #1;
        total++; if (inst !== 8'hFF) begin bad++; $display("FAIL ovf_inst_ff got=%0h want=ff", inst); end
        total++; if (pc_oob !== 1'b0) begin bad++; $display("FAIL ovf_pc_oob got=%0h want=0", pc_oob); end
        pc = 8'h80;
        #1;
        total++; if (inst !== 8'h80) begin bad++; $display("FAIL ovf_inst_80 got=%0h want=80", inst); end
    endtask

    task automatic test_restart();
        pulse_start();
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rs_overflow_clr got=%0h want=0", overflow); end
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL rs_run_drop got=%0h want=0", cpu_run); end
        beat(8'hAA, 1'b0);
        beat(8'hBB, 1'b0);
        ldif.load_start = 1'b1;
        ldif.load_valid = 1'b1;
        ldif.load_data  = 8'h11;
        step();
        ldif.load_start = 1'b0;
        ldif.load_valid = 1'b0;
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL rs_len_zero got=%0d want=0", prog_len); end
        beat(8'h22, 1'b1);
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL rs_prog_len got=%0d want=1", prog_len); end
        pc = 8'h00;
        #1;
        total++; if (inst !== 8'h22) begin bad++; $display("FAIL rs_inst0 got=%0h want=22", inst); end
        pc = 8'h01;
        #1;
        total++; if (inst !== 8'h00) begin bad++; $display("FAIL rs_inst1 got=%0h want=00", inst); end
        total++; if (pc_oob !== 1'b1) begin bad++; $display("FAIL rs_pc_oob got=%0h want=1", pc_oob); end
    endtask

    task automatic test_async_reset();
        int n;
        pulse_start();
        beat(8'h5A, 1'b0);
        beat(8'h6B, 1'b0);
        beat(8'h7C, 1'b1);
        total++; if (cpu_run !== 1'b1) begin bad++; $display("FAIL ar_run_before got=%0h want=1", cpu_run); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++; if (cpu_run !== 1'b0) begin bad++; $display("FAIL ar_cpu_run got=%0h want=0", cpu_run); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL ar_busy got=%0h want=1", busy); end
        total++; if (prog_len !== 9'd0) begin bad++; $display("FAIL ar_prog_len got=%0d want=0", prog_len); end
        #10;
        reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 600) begin
            step();
            n++;
        end
        total++; if (n !== 256) begin bad++; $display("FAIL ar_clear_cycles got=%0d want=256", n); end
        pulse_start();
        beat(8'h99, 1'b1);
        total++; if (prog_len !== 9'd1) begin bad++; $display("FAIL ar_prog_len_new got=%0d want=1", prog_len); end
        for (int i = 0; i < 3; i++) begin
            pc = 8'(i);
            #1;
            total++; if (inst !== ((i == 0) ? 8'h99 : 8'h00)) begin bad++; $display("FAIL ar_inst pc=%0d got=%0h want=%0h", i, inst, ((i == 0) ? 8'h99 : 8'h00)); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        pc    = 8'h00;
        ldif.load_start = 1'b0;
        ldif.load_valid = 1'b0;
        ldif.load_data  = 8'h00;
        ldif.load_last  = 1'b0;

        test_reset();
        test_clear();
        test_basic_load();
        test_gaps();
        test_overflow();
        test_restart();
        test_async_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule : tb_imem_loader
